// File: rtl/register_file.sv
// rtl/register_file.sv - 8x16 register file, two registered read ports, sweep-clear FSM
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding in IDLE)
module register_file #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] write_address,
    input  logic              is_write,
    input  logic [ADDR_W-1:0] read_addr_a,
    input  logic [ADDR_W-1:0] read_addr_b,
    output logic [DATA_W-1:0] read_data_a,
    output logic [DATA_W-1:0] read_data_b,
    input  logic              clear_req,
    output logic              busy
);

    localparam int              NUM_REGS = 2**ADDR_W;
    // Last register index the sweep clears; the counter then steps one past it and stops.
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(NUM_REGS - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] rd_a_q, rd_a_d;
    logic [DATA_W-1:0] rd_b_q, rd_b_d;

    logic              wr_en;
    logic [ADDR_W-1:0] sweep_idx;

    // Upstream writes are honoured only while idle; during a sweep they are dropped.
    assign wr_en     = (state_q == IDLE) && is_write;
    assign sweep_idx = cnt_q[ADDR_W-1:0];

    assign busy        = (state_q == SWEEP);
    assign read_data_a = rd_a_q;
    assign read_data_b = rd_b_q;

    // Sweep FSM: start on clear_req in IDLE, clear one register per cycle, stop after the last.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Register array next state: upstream write in IDLE, zero the swept entry in SWEEP.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en) begin
            regs_d[write_address] = write_data;
        end else if (state_q == SWEEP) begin
            regs_d[sweep_idx] = '0;
        end
    end

    // Read ports: pre-write contents, optionally forwarded from a same-cycle idle write.
    always_comb begin
        rd_a_d = regs_q[read_addr_a];
        rd_b_d = regs_q[read_addr_b];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (write_address == read_addr_a)) begin
            rd_a_d = write_data;
        end
        if (wr_en && (write_address == read_addr_b)) begin
            rd_b_d = write_data;
        end
`else
`endif
    end

    // State update; reset abandons any sweep and clears every register and read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule
